// File: rtl/cl_bit_serial.sv
// Bit-serial sequencer around the 1-bit logic cell cl, LSB first.
// Optional `zero` flag output enabled by defining CL_SERIAL_ZERO_EN.

module cl (
    output logic       out,
    input  logic       a,
    input  logic       b,
    input  logic [1:0] s
);

    always_comb begin
        out = 1'b0;
        unique case (s)
            2'b00: out = a & b;
            2'b01: out = a | b;
            2'b10: out = a ^ b;
            2'b11: out = ~a;
        endcase
    end

endmodule

module cl_bit_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
`ifdef CL_SERIAL_ZERO_EN
    output logic             zero,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nx;
    logic [1:0]       op_q;
    logic             cell_out;
    logic             last;
    logic             load;
    logic             step;
    logic             finish;

    cl u_cl (
        .out (cell_out),
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .s   (op_q)
    );

    // Cell output enters at the MSB so the LSB-first stream lands in place.
    assign res_nx = {cell_out, res_sh[WIDTH-1:1]};
    assign last   = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            op_q   <= 2'b00;
        end else if (load) begin
            cnt    <= '0;
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            op_q   <= op;
        end else if (step) begin
            cnt    <= cnt + CW'(1);
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nx;
        end
    end

    // Result only moves on the completion edge, never showing partials.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
        end else if (finish) begin
            result <= res_nx;
        end
    end

`ifdef CL_SERIAL_ZERO_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero <= 1'b1;
        end else if (finish) begin
            zero <= ~|res_nx;
        end
    end
`endif

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_cl_bit_serial.sv
// Self-checking bench for cl_bit_serial: vector table, corner
// sequences and randomized ops against a word-level model.

module tb_cl_bit_serial;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
`ifdef CL_SERIAL_ZERO_EN
    logic         zero;
`endif

    int tests;
    int failed;

    cl_bit_serial #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
`ifdef CL_SERIAL_ZERO_EN
        .zero    (zero),
`endif
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    function automatic logic [W-1:0] model(input logic [1:0] o,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~x;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at the negedge after E0; lat = negedges until done seen.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int i = 0; i < 4 * W; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, output int lat,
                          output int busy_n);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        wait_done(lat, busy_n);
    endtask

    vec_t         vt[7];
    int           lat;
    int           bn;
    logic [W-1:0] exp_r;
    logic [W-1:0] held;
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           saw;

    initial begin
        tests   = 0;
        failed  = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;

        vt[0] = '{2'b00, 8'hF0, 8'h3C, 8'h30};
        vt[1] = '{2'b01, 8'hA0, 8'h05, 8'hA5};
        vt[2] = '{2'b10, 8'hFF, 8'h0F, 8'hF0};
        vt[3] = '{2'b11, 8'h5A, 8'hFF, 8'hA5};
        vt[4] = '{2'b10, 8'h33, 8'h33, 8'h00};
        vt[5] = '{2'b00, 8'hFF, 8'hFF, 8'hFF};
        vt[6] = '{2'b11, 8'hFF, 8'h00, 8'h00};

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
`ifdef CL_SERIAL_ZERO_EN
        check("rst_zero", 32'(zero), 32'd1);
`endif
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, lat, bn);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(W));
            check($sformatf("vec%0d_busy", i), 32'(bn), 32'(W));
            check($sformatf("vec%0d_res", i), 32'(result), 32'(vt[i].exp));
`ifdef CL_SERIAL_ZERO_EN
            check($sformatf("vec%0d_zero", i), 32'(zero),
                  32'(vt[i].exp == '0));
`endif
            held = result;
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_hold", i), 32'(result), 32'(held));
        end

        // start during SHIFT is ignored
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 8'hFF;
        b     = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bn);
        check("ign_lat", 32'(lat), 32'(W - 3));
        check("ign_res", 32'(result), 32'hFF);
        @(negedge clk);
        check("ign_idle", 32'(busy), 32'd0);

        // reset mid-operation
        start = 1'b1;
        op    = 2'b01;
        a     = 8'h0F;
        b     = 8'h00;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_res", 32'(result), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        saw = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        check("rst_no_done", 32'(saw), 32'd0);
        run_op(2'b01, 8'h0F, 8'h00, lat, bn);
        check("rst_new_lat", 32'(lat), 32'(W));
        check("rst_new_res", 32'(result), 32'h0F);

        // back-to-back start in the DONE cycle
        run_op(2'b00, 8'h0F, 8'hFF, lat, bn);
        check("b2b_first", 32'(result), 32'h0F);
        start = 1'b1;
        op    = 2'b10;
        a     = 8'h01;
        b     = 8'h03;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_nodone", 32'(done), 32'd0);
        wait_done(lat, bn);
        check("b2b_lat", 32'(lat), 32'(W));
        check("b2b_res", 32'(result), 32'h02);

        // randomized ops against the word-level model
        for (int k = 0; k < 40; k++) begin
            ro    = 2'($urandom);
            ra    = W'($urandom);
            rb    = W'($urandom);
            if (k % 8 == 0) rb = ~ra;
            exp_r = model(ro, ra, rb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(ro, ra, rb, lat, bn);
            check($sformatf("rnd%0d_lat", k), 32'(lat), 32'(W));
            check($sformatf("rnd%0d_res", k), 32'(result), 32'(exp_r));
`ifdef CL_SERIAL_ZERO_EN
            check($sformatf("rnd%0d_zero", k), 32'(zero),
                  32'(exp_r == '0));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
